// File: rtl/feature_loader.sv
// rtl/feature_loader.sv - streams stored node feature vectors from BRAM as packed vectors
module feature_loader #(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int NUM_SUBGRAPHS     = 2708,
  parameter int READ_LATENCY      = 2,
  localparam int ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
  localparam int NODE_W = $clog2(NUM_SUBGRAPHS),
  localparam int OUT_W  = NUM_FEATURE_OUT * NEW_FEATURE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [ADDR_W-1:0]            feat_bram_addrb,
  output logic                         feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_doutb,
  output logic [OUT_W-1:0]             feat_out,
  output logic [NODE_W-1:0]            feat_out_node,
  output logic                         feat_out_vld,
  input  logic                         feat_out_rdy,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(NUM_FEATURE_OUT);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  state_t                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    enb_q;
  logic [CW-1:0]           rd_cnt_q;
  logic [NODE_W-1:0]       node_q;
  logic                    busy_q;
  logic                    done_q;
  logic [READ_LATENCY-1:0] vpipe_q;
  logic [CW-1:0]           cap_cnt_q;
  logic [OUT_W-1:0]        asm_q;
  logic                    asm_full_q;
  logic [OUT_W-1:0]        out_q;
  logic [NODE_W-1:0]       out_node_q;
  logic                    vld_q;
  logic                    hs;
  logic                    xfer;
  logic [CW-1:0]           lane;

  assign hs   = vld_q & feat_out_rdy;
  assign xfer = asm_full_q & (~vld_q | feat_out_rdy);
  // NUM_FEATURE_OUT is a power of two, so NUM_FEATURE_OUT-1-k is the bitwise inverse of k
  assign lane = ~cap_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      enb_q    <= 1'b0;
      rd_cnt_q <= '0;
      node_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FETCH;
            addr_q   <= '0;
            enb_q    <= 1'b1;
            rd_cnt_q <= '0;
            node_q   <= '0;
            busy_q   <= 1'b1;
          end
        end
        FETCH: begin
          rd_cnt_q <= rd_cnt_q + CW'(1);
          if (rd_cnt_q == CW'(NUM_FEATURE_OUT - 1)) begin
            enb_q   <= 1'b0;
            state_q <= WAIT;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        WAIT: begin
          // next node is fetched only once the assembly register has been emptied
          if (xfer) begin
            if (node_q < NODE_W'(NUM_SUBGRAPHS - 1)) begin
              node_q  <= node_q + NODE_W'(1);
              addr_q  <= addr_q + ADDR_W'(1);
              enb_q   <= 1'b1;
              state_q <= FETCH;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_q    <= '0;
      cap_cnt_q  <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      out_q      <= '0;
      out_node_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) vpipe_q[i] <= vpipe_q[i-1];
      vpipe_q[0] <= enb_q;
      if (vpipe_q[READ_LATENCY-1]) begin
        asm_q[lane*NEW_FEATURE_WIDTH +: NEW_FEATURE_WIDTH] <= feat_bram_doutb;
        cap_cnt_q <= cap_cnt_q + CW'(1);
        if (cap_cnt_q == CW'(NUM_FEATURE_OUT - 1)) asm_full_q <= 1'b1;
      end
      if (xfer) begin
        out_q      <= asm_q;
        out_node_q <= node_q;
        vld_q      <= 1'b1;
        asm_full_q <= 1'b0;
      end else if (hs) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign feat_bram_addrb = addr_q;
  assign feat_bram_enb   = enb_q;
  assign feat_out        = out_q;
  assign feat_out_node   = out_node_q;
  assign feat_out_vld    = vld_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_feature_loader.sv
// tb/tb_feature_loader.sv - directed bench for feature_loader (4 words, 3 nodes, latency 2)
module tb_feature_loader;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int S  = 3;
  localparam int L  = 2;
  localparam int AW = 4;
  localparam int NW = 2;
  localparam int OW = N * W;

  logic          clk = 1'b0;
  logic          rst, start, rdy;
  logic [AW-1:0] addrb;
  logic          enb;
  logic [W-1:0]  doutb;
  logic [OW-1:0] feat_out;
  logic [NW-1:0] node;
  logic          vld, busy, done;

  int total = 0;
  int bad   = 0;

  feature_loader #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(N), .NUM_SUBGRAPHS(S),
                   .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start),
    .feat_bram_addrb(addrb), .feat_bram_enb(enb), .feat_bram_doutb(doutb),
    .feat_out(feat_out), .feat_out_node(node), .feat_out_vld(vld),
    .feat_out_rdy(rdy), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // BRAM model: mem[a] = a, data visible READ_LATENCY cycles after the enb cycle
  logic [W-1:0] st0, st1;
  always @(posedge clk) begin
    st0 <= enb ? W'(addrb) : 32'hdead_beef;
    st1 <= st0;
  end
  assign doutb = st1;

  // monitor on the falling edge: handshakes, done pulses, address range, output stability
  logic [NW-1:0] hs_node[$];
  logic [OW-1:0] hs_data[$];
  int            done_cnt = 0;
  int            addr_max = 0;
  int            stab_bad = 0;
  logic          p_vld = 1'b0, p_rdy = 1'b0;
  logic [OW-1:0] p_out;
  logic [NW-1:0] p_node;
  always @(negedge clk) begin
    if (rst) begin
      p_vld = 1'b0;
    end else begin
      if (p_vld && !p_rdy && !(vld && feat_out === p_out && node === p_node)) stab_bad++;
      if (vld && rdy) begin
        hs_node.push_back(node);
        hs_data.push_back(feat_out);
      end
      if (done) done_cnt++;
      if (enb && int'(addrb) > addr_max) addr_max = int'(addrb);
      p_vld = vld; p_rdy = rdy; p_out = feat_out; p_node = node;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] vec(input int n);
    return {W'(4*n), W'(4*n+1), W'(4*n+2), W'(4*n+3)};
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) tick();
    chk(tag, OW'(busy), OW'(0));
    repeat (2) tick();
  endtask

  task automatic check_run(input string tag, input int base, input int done_base);
    chk({tag, "_count"}, OW'(hs_node.size() - base), OW'(3));
    for (int k = 0; k < 3; k++) begin
      if (base + k < hs_node.size()) begin
        chk($sformatf("%s_node%0d", tag, k), OW'(hs_node[base+k]), OW'(k));
        chk($sformatf("%s_data%0d", tag, k), hs_data[base+k], vec(k));
      end
    end
    chk({tag, "_done"}, OW'(done_cnt - done_base), OW'(1));
  endtask

  initial begin
    int base, dbase, vcnt;
    rst = 1'b1; start = 1'b0; rdy = 1'b1;
    repeat (2) tick();
    chk("rst_enb", OW'(enb), OW'(0));
    chk("rst_addr", OW'(addrb), OW'(0));
    chk("rst_out", feat_out, OW'(0));
    chk("rst_node", OW'(node), OW'(0));
    chk("rst_vld", OW'(vld), OW'(0));
    chk("rst_busy_done", OW'({busy, done}), OW'(0));
    rst = 1'b0;
    tick();

    // cycle 0: start; reads at cycles 1-4, first vector at cycle 8
    base = hs_node.size(); dbase = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("c1_busy", OW'(busy), OW'(1));
    chk("c1_enb", OW'(enb), OW'(1));
    chk("c1_addr", OW'(addrb), OW'(0));
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("c%0d_enb_addr", k+1), OW'({enb, addrb}), OW'({1'b1, 4'(k)}));
    end
    tick();
    chk("c5_enb", OW'(enb), OW'(0));
    repeat (2) tick();
    chk("c7_vld", OW'(vld), OW'(0));
    tick();
    chk("c8_vld", OW'(vld), OW'(1));
    chk("c8_data", feat_out, vec(0));
    chk("c8_node", OW'(node), OW'(0));
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("runA_timeout");
    check_run("runA", base, dbase);
    chk("addr_max", OW'(addr_max), OW'(11));

    // back-pressure: hold rdy low 20 cycles after the first vector
    base = hs_node.size(); dbase = done_cnt;
    rdy = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && !vld; i++) tick();
    chk("bp_first_vld", OW'(vld), OW'(1));
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (enb && addrb >= 4'd8) vcnt++;
      tick();
    end
    chk("bp_no_node2_read", OW'(vcnt), OW'(0));
    chk("bp_hold_vld", OW'(vld), OW'(1));
    chk("bp_hold_node", OW'(node), OW'(0));
    chk("bp_hold_data", feat_out, vec(0));
    rdy = 1'b1;
    wait_idle("runB_timeout");
    check_run("runB", base, dbase);
    chk("stability", OW'(stab_bad), OW'(0));

    // reset during node-1 fetch, then replay from node 0
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && !(enb && addrb == 4'd5); i++) tick();
    chk("mid_reached", OW'({enb, addrb}), OW'({1'b1, 4'd5}));
    rst = 1'b1;
    #1;
    chk("mid_rst_enb_addr", OW'({enb, addrb}), OW'(0));
    chk("mid_rst_out", feat_out, OW'(0));
    chk("mid_rst_flags", OW'({vld, busy, done, node}), OW'(0));
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (vld || enb) vcnt++;
    end
    chk("post_rst_silent", OW'(vcnt), OW'(0));
    base = hs_node.size(); dbase = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("runC_timeout");
    check_run("runC", base, dbase);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
